// File: rtl/cfg_reg_file_if.sv
// Software/hardware access bus of the configuration register file.
// The controller side drives requests (master); the register file answers (slave).
interface cfg_reg_file_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4
);
   logic                     WR_EN;
   logic                     RD_EN;
   logic [ADDRESS_WIDTH-1:0] Address;
   logic [DATA_WIDTH-1:0]    WR_DATA;
   logic [DATA_WIDTH-1:0]    WR_MASK;
   logic                     HW_UPD_EN;
   logic [DATA_WIDTH-1:0]    HW_UPD_DATA;
   logic [DATA_WIDTH-1:0]    RD_DATA;
   logic                     RdData_valid;
   logic                     ACC_ERR;
   logic [DATA_WIDTH-1:0]    REG0;
   logic [DATA_WIDTH-1:0]    REG1;
   logic [DATA_WIDTH-1:0]    REG2;
   logic [DATA_WIDTH-1:0]    REG3;

   modport master (
      output WR_EN, RD_EN, Address, WR_DATA, WR_MASK, HW_UPD_EN, HW_UPD_DATA,
      input  RD_DATA, RdData_valid, ACC_ERR, REG0, REG1, REG2, REG3
   );

   modport slave (
      input  WR_EN, RD_EN, Address, WR_DATA, WR_MASK, HW_UPD_EN, HW_UPD_DATA,
      output RD_DATA, RdData_valid, ACC_ERR, REG0, REG1, REG2, REG3
   );
endinterface

// File: rtl/cfg_reg_file.sv
// Configuration register file: masked software writes, pipelined software
// reads (1 or 2 cycle latency), one hardware-updated register, and a single
// error pulse for rejected accesses. Registers 0-3 are also exposed directly.
module cfg_reg_file #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    ADDRESS_WIDTH = 4,
   parameter int                    DEPTH         = 16,
   parameter int                    RD_LATENCY    = 1,
   parameter logic [DEPTH-1:0]      RO_MASK       = '0,
   parameter int                    HW_ADDR       = 2,
   parameter logic [DATA_WIDTH-1:0] HW_MASK       = '1,
   parameter logic [DATA_WIDTH-1:0] RST_VAL2      = DATA_WIDTH'(8'b001000_01),
   parameter logic [DATA_WIDTH-1:0] RST_VAL3      = DATA_WIDTH'(8'd32)
) (
   input logic           CLK,
   input logic           RST,
   cfg_reg_file_if.slave bus
);

   logic [DATA_WIDTH-1:0] reg_q [DEPTH];
   logic [DATA_WIDTH-1:0] reg_d [DEPTH];

   logic [DEPTH-1:0]      addr_hit;
   logic                  in_range;
   logic                  ro_hit;
   logic                  sw_wr;
   logic                  sw_rd;
   logic                  wr_ok;
   logic                  wr_err;
   logic                  rd_err;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  out_vld;
   logic                  out_err;
   logic [DATA_WIDTH-1:0] out_data;

   logic                  rd_vld_q, rd_vld_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  acc_err_q, acc_err_d;

   function automatic logic [DATA_WIDTH-1:0] rst_val(input int idx);
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      if (idx == 2) v = RST_VAL2;
      if (idx == 3) v = RST_VAL3;
      return v;
   endfunction

   // Address decode and request classification; out-of-range addresses hit nothing
   always_comb begin
      addr_hit = '0;
      rd_word  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         addr_hit[i] = (bus.Address == ADDRESS_WIDTH'(i));
         rd_word     = rd_word | ({DATA_WIDTH{addr_hit[i]}} & reg_q[i]);
      end
      in_range = |addr_hit;
      ro_hit   = |(addr_hit & RO_MASK);
      sw_wr    = bus.WR_EN & ~bus.RD_EN;
      sw_rd    = bus.RD_EN & ~bus.WR_EN;
      wr_ok    = sw_wr & in_range & ~ro_hit;
      // a simultaneous read+write request is charged to the write side
      wr_err   = bus.WR_EN & (bus.RD_EN | ~in_range | ro_hit);
      rd_err   = sw_rd & ~in_range;
   end

   // Next register contents: software masked write, then hardware bits override
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         reg_d[i] = reg_q[i];
         if (wr_ok && addr_hit[i]) begin
            reg_d[i] = (reg_q[i] & ~bus.WR_MASK) | (bus.WR_DATA & bus.WR_MASK);
         end
         if (bus.HW_UPD_EN && (i == HW_ADDR)) begin
            reg_d[i] = (reg_d[i] & ~HW_MASK) | (bus.HW_UPD_DATA & HW_MASK);
         end
      end
   end

   // Register storage with per-register reset values
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) reg_q[i] <= rst_val(i);
      end else begin
         for (int i = 0; i < DEPTH; i++) reg_q[i] <= reg_d[i];
      end
   end

   // Read pipeline: the extra stage only exists for two-cycle latency
   if (RD_LATENCY == 2) begin : g_lat2
      logic                  p_vld_q, p_vld_d;
      logic                  p_err_q, p_err_d;
      logic [DATA_WIDTH-1:0] p_data_q, p_data_d;

      // First read stage captures the word at the request edge
      always_comb begin
         p_vld_d  = sw_rd;
         p_err_d  = rd_err;
         p_data_d = p_data_q;
         if (sw_rd) p_data_d = rd_word;
      end

      // First read stage flops; reset drops any read in flight
      always_ff @(posedge CLK or negedge RST) begin
         if (!RST) begin
            p_vld_q  <= 1'b0;
            p_err_q  <= 1'b0;
            p_data_q <= '0;
         end else begin
            p_vld_q  <= p_vld_d;
            p_err_q  <= p_err_d;
            p_data_q <= p_data_d;
         end
      end

      assign out_vld  = p_vld_q;
      assign out_err  = p_err_q;
      assign out_data = p_data_q;
   end else begin : g_lat1
      assign out_vld  = sw_rd;
      assign out_err  = rd_err;
      assign out_data = rd_word;
   end

   // Output stage: data holds between valids, error merges read and write faults
   always_comb begin
      rd_vld_d  = out_vld;
      rd_data_d = out_vld ? out_data : rd_data_q;
      acc_err_d = out_err | wr_err;
   end

   // Output stage flops
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
         acc_err_q <= 1'b0;
      end else begin
         rd_vld_q  <= rd_vld_d;
         rd_data_q <= rd_data_d;
         acc_err_q <= acc_err_d;
      end
   end

   assign bus.RD_DATA      = rd_data_q;
   assign bus.RdData_valid = rd_vld_q;
   assign bus.ACC_ERR      = acc_err_q;
   assign bus.REG0         = reg_q[0];
   assign bus.REG1         = reg_q[1];
   assign bus.REG2         = reg_q[2];
   assign bus.REG3         = reg_q[3];

endmodule

// File: tb/tb_cfg_reg_file.sv
// Two register files driven with identical stimulus:
//   a: DEPTH 16, latency 1, register 4 read-only, hardware mask 0x03
//   b: DEPTH 12, latency 2, register 7 read-only, hardware mask 0xF0
// Expected behaviour comes from a per-instance array model plus a schedule of
// expected output events indexed by clock edge.
module tb_cfg_reg_file;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       wr_en = 1'b0, rd_en = 1'b0, hw_en = 1'b0;
   logic [4:0] addr = '0;
   logic [7:0] wdata = '0, wmask = '0, hwdata = '0;

   always #5 clk = ~clk;

   cfg_reg_file_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(5)) bus_a ();
   cfg_reg_file_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(5)) bus_b ();

   assign bus_a.WR_EN = wr_en;        assign bus_b.WR_EN = wr_en;
   assign bus_a.RD_EN = rd_en;        assign bus_b.RD_EN = rd_en;
   assign bus_a.Address = addr;       assign bus_b.Address = addr;
   assign bus_a.WR_DATA = wdata;      assign bus_b.WR_DATA = wdata;
   assign bus_a.WR_MASK = wmask;      assign bus_b.WR_MASK = wmask;
   assign bus_a.HW_UPD_EN = hw_en;    assign bus_b.HW_UPD_EN = hw_en;
   assign bus_a.HW_UPD_DATA = hwdata; assign bus_b.HW_UPD_DATA = hwdata;

   cfg_reg_file #(.DATA_WIDTH(8), .ADDRESS_WIDTH(5), .DEPTH(16), .RD_LATENCY(1),
                  .RO_MASK(16'h0010), .HW_ADDR(2), .HW_MASK(8'h03))
      dut_a (.CLK(clk), .RST(rst_n), .bus(bus_a));

   cfg_reg_file #(.DATA_WIDTH(8), .ADDRESS_WIDTH(5), .DEPTH(12), .RD_LATENCY(2),
                  .RO_MASK(12'h080), .HW_ADDR(2), .HW_MASK(8'hF0))
      dut_b (.CLK(clk), .RST(rst_n), .bus(bus_b));

   logic       o_vld [2];
   logic       o_err [2];
   logic [7:0] o_rd  [2];
   logic [7:0] o_reg [2][4];

   always_comb begin
      o_vld[0] = bus_a.RdData_valid; o_vld[1] = bus_b.RdData_valid;
      o_err[0] = bus_a.ACC_ERR;      o_err[1] = bus_b.ACC_ERR;
      o_rd[0]  = bus_a.RD_DATA;      o_rd[1]  = bus_b.RD_DATA;
      o_reg[0][0] = bus_a.REG0; o_reg[0][1] = bus_a.REG1;
      o_reg[0][2] = bus_a.REG2; o_reg[0][3] = bus_a.REG3;
      o_reg[1][0] = bus_b.REG0; o_reg[1][1] = bus_b.REG1;
      o_reg[1][2] = bus_b.REG2; o_reg[1][3] = bus_b.REG3;
   end

   // reference model
   logic [7:0] mem [2][16];
   bit         sv  [2][8];
   bit         se  [2][8];
   logic [7:0] sd  [2][8];
   bit         e_vld [2];
   bit         e_err [2];
   logic [7:0] e_rd  [2];
   int         n;
   int         passed = 0;
   int         total  = 0;

   function automatic int depth_of(input int k);  return (k == 0) ? 16 : 12; endfunction
   function automatic int lat_of(input int k);    return (k == 0) ? 1 : 2;   endfunction
   function automatic logic [31:0] ro_of(input int k);
      return (k == 0) ? 32'h0010 : 32'h0080;
   endfunction
   function automatic logic [7:0] hwm_of(input int k);
      return (k == 0) ? 8'h03 : 8'hF0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) mem[k][i] = (i == 2) ? 8'h21 : (i == 3) ? 8'h20 : 8'h00;
         for (int s = 0; s < 8; s++) begin sv[k][s] = 0; se[k][s] = 0; sd[k][s] = 0; end
         e_vld[k] = 0; e_err[k] = 0; e_rd[k] = 8'h00;
      end
      n = 0;
   endtask

   task automatic drive(input logic w, input logic r, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] m,
                        input logic h, input logic [7:0] hd);
      wr_en = w; rd_en = r; addr = a; wdata = d; wmask = m; hw_en = h; hwdata = hd;
   endtask

   task automatic idle();
      drive(0, 0, 5'd0, 8'h00, 8'h00, 0, 8'h00);
   endtask

   // One clock edge: advance the model with the inputs sampled at that edge and
   // publish what the outputs must show until the next edge.
   task automatic step();
      int a, slot;
      bit inr, isro;
      @(posedge clk);
      #1;
      n++;
      a = int'(addr);
      for (int k = 0; k < 2; k++) begin
         inr  = a < depth_of(k);
         isro = inr && ro_of(k)[a];
         if (rd_en && !wr_en) begin
            slot = (n + lat_of(k) - 1) % 8;
            sv[k][slot] = 1;
            sd[k][slot] = inr ? mem[k][a] : 8'h00;
            if (!inr) se[k][slot] = 1;
         end
         if (wr_en && (rd_en || !inr || isro)) se[k][n % 8] = 1;
         if (wr_en && !rd_en && inr && !isro)
            mem[k][a] = (mem[k][a] & ~wmask) | (wdata & wmask);
         if (hw_en)
            mem[k][2] = (mem[k][2] & ~hwm_of(k)) | (hwdata & hwm_of(k));
         e_vld[k] = sv[k][n % 8];
         e_err[k] = se[k][n % 8];
         if (e_vld[k]) e_rd[k] = sd[k][n % 8];
         sv[k][n % 8] = 0; se[k][n % 8] = 0;
      end
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] rv [4];
      rv[0] = 8'h00; rv[1] = 8'h00; rv[2] = 8'h21; rv[3] = 8'h20;
      idle();
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if (o_vld[k] !== 1'b0 || o_err[k] !== 1'b0 || o_rd[k] !== 8'h00)
            $display("FAIL reset_out[%0d]: got vld=%b err=%b rd=%h, want 0 0 00", k, o_vld[k], o_err[k], o_rd[k]);
         else passed++;
         for (int i = 0; i < 4; i++) begin
            total++;
            if (o_reg[k][i] !== rv[i])
               $display("FAIL reset_reg[%0d][%0d]: got %h want %h", k, i, o_reg[k][i], rv[i]);
            else passed++;
         end
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_readback();
      logic [7:0] ev [4];
      ev[0] = 8'h00; ev[1] = 8'h00; ev[2] = 8'h21; ev[3] = 8'h20;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 5'(i), 8'h00, 8'h00, 0, 8'h00);
         step();
         total++;
         if (o_vld[0] !== 1'b1 || o_rd[0] !== ev[i])
            $display("FAIL readback_a[%0d]: got vld=%b rd=%h want 1 %h", i, o_vld[0], o_rd[0], ev[i]);
         else passed++;
         total++;
         if (o_vld[1] !== e_vld[1] || o_rd[1] !== e_rd[1])
            $display("FAIL readback_b[%0d]: got vld=%b rd=%h want %b %h", i, o_vld[1], o_rd[1], e_vld[1], e_rd[1]);
         else passed++;
      end
      idle();
      step();
      total++;
      if (o_vld[0] !== 1'b0 || o_rd[0] !== 8'h20 || o_vld[1] !== 1'b1 || o_rd[1] !== 8'h20)
         $display("FAIL readback_tail: got a=%b/%h b=%b/%h want 0/20 1/20", o_vld[0], o_rd[0], o_vld[1], o_rd[1]);
      else passed++;
      step();
      total++;
      if (o_vld[1] !== 1'b0 || o_rd[1] !== 8'h20)
         $display("FAIL readback_hold_b: got vld=%b rd=%h want 0 20", o_vld[1], o_rd[1]);
      else passed++;
   endtask

   task automatic test_masked_write();
      drive(1, 0, 5'd5, 8'hA5, 8'h0F, 0, 8'h00);
      step();
      drive(0, 1, 5'd5, 8'h00, 8'h00, 0, 8'h00);
      step();
      total++;
      if (o_vld[0] !== 1'b1 || o_rd[0] !== 8'h05 || o_vld[1] !== 1'b0)
         $display("FAIL mwrite_lat1: got a=%b/%h b_vld=%b want 1/05 0", o_vld[0], o_rd[0], o_vld[1]);
      else passed++;
      idle();
      step();
      total++;
      if (o_vld[1] !== 1'b1 || o_rd[1] !== 8'h05 || o_vld[0] !== 1'b0)
         $display("FAIL mwrite_lat2: got b=%b/%h a_vld=%b want 1/05 0", o_vld[1], o_rd[1], o_vld[0]);
      else passed++;
      step();
   endtask

   task automatic test_ro_and_range();
      drive(1, 0, 5'd4, 8'hFF, 8'hFF, 0, 8'h00);
      step();
      total++;
      if (o_err[0] !== 1'b1 || o_err[1] !== 1'b0)
         $display("FAIL ro_err: got a=%b b=%b want 1 0", o_err[0], o_err[1]);
      else passed++;
      drive(0, 1, 5'd4, 8'h00, 8'h00, 0, 8'h00);
      step();
      total++;
      if (o_err[0] !== 1'b0 || o_vld[0] !== 1'b1 || o_rd[0] !== 8'h00)
         $display("FAIL ro_unchanged: got err=%b vld=%b rd=%h want 0 1 00", o_err[0], o_vld[0], o_rd[0]);
      else passed++;
      drive(0, 1, 5'd20, 8'h00, 8'h00, 0, 8'h00);
      step();
      total++;
      if (o_vld[0] !== 1'b1 || o_err[0] !== 1'b1 || o_rd[0] !== 8'h00)
         $display("FAIL range_a: got vld=%b err=%b rd=%h want 1 1 00", o_vld[0], o_err[0], o_rd[0]);
      else passed++;
      total++;
      if (o_vld[1] !== 1'b1 || o_rd[1] !== 8'hFF || o_err[1] !== 1'b0)
         $display("FAIL rw_b4: got vld=%b rd=%h err=%b want 1 ff 0", o_vld[1], o_rd[1], o_err[1]);
      else passed++;
      idle();
      step();
      total++;
      if (o_vld[1] !== 1'b1 || o_err[1] !== 1'b1 || o_rd[1] !== 8'h00 || o_err[0] !== 1'b0)
         $display("FAIL range_b: got vld=%b err=%b rd=%h a_err=%b want 1 1 00 0", o_vld[1], o_err[1], o_rd[1], o_err[0]);
      else passed++;
      step();
   endtask

   task automatic test_hw_collision();
      drive(1, 0, 5'd2, 8'hFF, 8'hFF, 1, 8'h00);
      step();
      total++;
      if (o_reg[0][2] !== 8'hFC || o_reg[1][2] !== 8'h0F)
         $display("FAIL hw_collide: got a=%h b=%h want fc 0f", o_reg[0][2], o_reg[1][2]);
      else passed++;
      // a read in the same cycle as a hardware update sees the old value
      drive(0, 1, 5'd2, 8'h00, 8'h00, 1, 8'h5A);
      step();
      total++;
      if (o_rd[0] !== 8'hFC || o_reg[0][2] !== 8'hFE)
         $display("FAIL hw_pre_read: got rd=%h reg=%h want fc fe", o_rd[0], o_reg[0][2]);
      else passed++;
      idle();
      step();
      total++;
      if (o_rd[1] !== 8'h0F || o_reg[1][2] !== 8'h5F)
         $display("FAIL hw_pre_read_b: got rd=%h reg=%h want 0f 5f", o_rd[1], o_reg[1][2]);
      else passed++;
      step();
   endtask

   task automatic test_both_req();
      drive(1, 1, 5'd1, 8'h77, 8'hFF, 0, 8'h00);
      step();
      for (int k = 0; k < 2; k++) begin
         total++;
         if (o_err[k] !== 1'b1 || o_vld[k] !== 1'b0 || o_reg[k][1] !== 8'h00)
            $display("FAIL both_req[%0d]: got err=%b vld=%b reg1=%h want 1 0 00", k, o_err[k], o_vld[k], o_reg[k][1]);
         else passed++;
      end
      idle();
      repeat (2) begin
         step();
         total++;
         if (o_err[0] !== 1'b0 || o_err[1] !== 1'b0 || o_vld[0] !== 1'b0 || o_vld[1] !== 1'b0)
            $display("FAIL both_req_after: got err=%b/%b vld=%b/%b want all 0", o_err[0], o_err[1], o_vld[0], o_vld[1]);
         else passed++;
      end
   endtask

   task automatic test_random();
      int r;
      for (int c = 0; c < 400; c++) begin
         r = $urandom_range(0, 9);
         drive(r <= 3 || r == 8, (r >= 4 && r <= 7) || r == 8, 5'($urandom_range(0, 20)),
               8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0, 8'($urandom));
         step();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (o_vld[k] !== e_vld[k] || o_err[k] !== e_err[k] || o_rd[k] !== e_rd[k])
               $display("FAIL rand_out[%0d] edge %0d: got vld=%b err=%b rd=%h want %b %b %h",
                        k, n, o_vld[k], o_err[k], o_rd[k], e_vld[k], e_err[k], e_rd[k]);
            else passed++;
            for (int i = 0; i < 4; i++) begin
               total++;
               if (o_reg[k][i] !== mem[k][i])
                  $display("FAIL rand_reg[%0d][%0d] edge %0d: got %h want %h", k, i, n, o_reg[k][i], mem[k][i]);
               else passed++;
            end
         end
      end
      idle();
      repeat (2) step();
   endtask

   task automatic test_reset_inflight();
      drive(0, 0, 5'd0, 8'h00, 8'h00, 1, 8'hFF);
      step();
      drive(0, 1, 5'd2, 8'h00, 8'h00, 0, 8'h00);
      step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (o_vld[1] !== 1'b0 || o_rd[1] !== 8'h00 || o_reg[1][2] !== 8'h21 || o_reg[1][3] !== 8'h20)
         $display("FAIL inflight_rst: got vld=%b rd=%h r2=%h r3=%h want 0 00 21 20", o_vld[1], o_rd[1], o_reg[1][2], o_reg[1][3]);
      else passed++;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         step();
         for (int k = 0; k < 2; k++) begin
            total++;
            if (o_vld[k] !== 1'b0 || o_reg[k][2] !== 8'h21 || o_reg[k][3] !== 8'h20)
               $display("FAIL inflight_after[%0d]: got vld=%b r2=%h r3=%h want 0 21 20", k, o_vld[k], o_reg[k][2], o_reg[k][3]);
            else passed++;
         end
      end
      // first edge after release accepts an access
      drive(1, 0, 5'd1, 8'h3C, 8'hFF, 0, 8'h00);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++;
      if (o_reg[0][1] !== 8'h3C || o_reg[1][1] !== 8'h3C)
         $display("FAIL first_edge: got a=%h b=%h want 3c 3c", o_reg[0][1], o_reg[1][1]);
      else passed++;
      idle();
   endtask

   initial begin
      #1;
      test_reset();
      test_readback();
      test_masked_write();
      test_ro_and_range();
      test_hw_collision();
      test_both_req();
      do_reset();
      test_random();
      test_reset_inflight();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cfg_reg_file.md
CFG_REG_FILE -- requirements
Module: cfg_reg_file

Interface
REQ-001: Parameter DATA_WIDTH, default 8, register width in bits.
REQ-002: Parameter ADDRESS_WIDTH, default 4, address bus width.
REQ-003: Parameter DEPTH, default 16, number of registers, 4 <= DEPTH <= 2^ADDRESS_WIDTH.
REQ-004: Parameter RD_LATENCY, default 1, read latency in cycles, legal values 1 or 2.
REQ-005: Parameter RO_MASK, default 0, DEPTH bits, bit i set marks register i read-only to the software port.
REQ-006: Parameter HW_ADDR, default 2, index of the hardware-updated register.
REQ-007: Parameter HW_MASK, default all-ones, DATA_WIDTH bits owned by the hardware update port.
REQ-008: Parameters RST_VAL2, default 8'b001000_01, and RST_VAL3, default 8'd32, reset values of registers 2 and 3.
REQ-009: CLK  input  1  sole clock; all state updates on rising edge.
REQ-010: RST  input  1  asynchronous, active-low reset.
REQ-011: WR_EN  input  1  software write request.
REQ-012: RD_EN  input  1  software read request.
REQ-013: Address  input  ADDRESS_WIDTH  software access index.
REQ-014: WR_DATA  input  DATA_WIDTH  write data.
REQ-015: WR_MASK  input  DATA_WIDTH  per-bit write enable, 1 = bit written.
REQ-016: HW_UPD_EN  input  1  hardware update strobe for register HW_ADDR.
REQ-017: HW_UPD_DATA  input  DATA_WIDTH  hardware update value.
REQ-018: RD_DATA  output  DATA_WIDTH  registered read data.
REQ-019: RdData_valid  output  1  one-cycle pulse qualifying RD_DATA.
REQ-020: ACC_ERR  output  1  one-cycle pulse flagging a rejected access.
REQ-021: REG0, REG1, REG2, REG3  output  DATA_WIDTH each  continuous view of registers 0-3.

Function
REQ-022: Write (WR_EN=1, RD_EN=0, Address<DEPTH, RO_MASK[Address]=0) SHALL update reg[Address] = (reg & ~WR_MASK) | (WR_DATA & WR_MASK) on the next edge.
REQ-023: Read (RD_EN=1, WR_EN=0) SHALL present reg[Address] sampled at the request edge on RD_DATA with RdData_valid=1 exactly RD_LATENCY cycles later, for one cycle.
REQ-024: Back-to-back reads SHALL be accepted every cycle, pipelined, results in request order.
REQ-025: RD_DATA SHALL hold its last value when RdData_valid=0.
REQ-026: Read with Address>=DEPTH SHALL return 0 with RdData_valid=1 on schedule and ACC_ERR=1 on the same cycle as that valid.
REQ-027: Write with Address>=DEPTH or to a read-only register SHALL leave all registers unchanged and pulse ACC_ERR on the next cycle.
REQ-028: WR_EN=1 and RD_EN=1 together SHALL perform neither access, produce no valid, and pulse ACC_ERR on the next cycle.
REQ-029: HW_UPD_EN=1 SHALL write HW_UPD_DATA into reg[HW_ADDR] bits set in HW_MASK on the next edge, regardless of RO_MASK and of software access.
REQ-030: Concurrent software write to HW_ADDR with HW_UPD_EN=1: HW_MASK bits take HW_UPD_DATA, remaining bits follow REQ-022.
REQ-031: A read issued in the same cycle as a write or hardware update of that register SHALL return the pre-update value.
REQ-032: Neither request active SHALL leave registers unchanged, with no valid and no ACC_ERR from that cycle.

Reset
REQ-033: RST low SHALL immediately set reg[2]=RST_VAL2, reg[3]=RST_VAL3, all other registers 0, RD_DATA=0, RdData_valid=0, ACC_ERR=0, and flush the read pipeline.
REQ-034: A read in flight when reset asserts SHALL never produce RdData_valid after reset release.
REQ-035: First access SHALL be accepted on the first rising edge with RST high.

Verification
REQ-036: Reset, then read addresses 0-3 back-to-back at RD_LATENCY=1 -> RD_DATA 0x00, 0x00, 0x21, 0x20, valid on four consecutive cycles starting one cycle after first request.
REQ-037: Write 0xA5 mask 0x0F to addr 5 (prior 0x00), read addr 5 -> 0x05; at RD_LATENCY=2, valid exactly two cycles after RD_EN.
REQ-038: RO_MASK bit 4 set, write 0xFF to addr 4 -> reg unchanged 0x00, ACC_ERR one pulse; Address=20 with DEPTH=16 read -> RD_DATA 0x00, valid and ACC_ERR together.
REQ-039: Same-cycle software write 0xFF mask 0xFF to addr 2 and HW_UPD_DATA 0x00 with HW_MASK 0x03 -> REG2=0xFC next cycle.
REQ-040: WR_EN and RD_EN both high -> no register change, no valid, ACC_ERR one pulse; RST low during RD_LATENCY=2 read -> no valid after release, REG2=0x21, REG3=0x20.
